// File: rtl/bcd_pkg.sv
// Shared BCD definitions for the four-digit counter.
// Provides the digit type, digit limits and the load-value saturation helper.
// Pure declarations: no ports, no state.
package bcd_pkg;

  typedef logic [3:0] bcd_t;

  localparam bcd_t BCD_MAX = 4'd9;
  localparam bcd_t BCD_MIN = 4'd0;

  // Clamp an arbitrary nibble into the legal decimal range.
  function automatic bcd_t bcd_sat(input logic [3:0] nib);
    return (nib > BCD_MAX) ? BCD_MAX : nib;
  endfunction

endpackage

// File: rtl/m_bcd_digit.sv
// One decade of the BCD counter: clear > load > step, wraps 9<->0.
// Ports: clk, rst_n (async low), i_step/i_up count request, i_clr, i_load, i_val;
//        o_val registered digit, o_carry/o_borrow combinational ripple to next decade.
module m_bcd_digit
  import bcd_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_step,
  input  logic       i_up,
  input  logic       i_clr,
  input  logic       i_load,
  input  logic [3:0] i_val,
  output logic [3:0] o_val,
  output logic       o_carry,
  output logic       o_borrow
);

  bcd_t val;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      val <= BCD_MIN;
    end else if (i_clr) begin
      val <= BCD_MIN;
    end else if (i_load) begin
      val <= bcd_sat(i_val);
    end else if (i_step) begin
      if (i_up) begin
        val <= (val == BCD_MAX) ? BCD_MIN : val + 4'd1;
      end else begin
        val <= (val == BCD_MIN) ? BCD_MAX : val - 4'd1;
      end
    end
  end

  // Carry/borrow are combinational so a full ripple (e.g. 9999->0000)
  // settles within the same cycle as the least significant step.
  assign o_carry  = i_step &&  i_up && (val == BCD_MAX);
  assign o_borrow = i_step && !i_up && (val == BCD_MIN);
  assign o_val    = val;

endmodule

// File: rtl/m_bcd_counter4.sv
// Four-digit BCD up/down counter with prescaler, clear, load and wrap flag.
// Ports: clk, rst_n (async low), i_en, i_up, i_clr, i_load, i_load_val[15:0];
//        o_digits[15:0] ([3:0] = units), o_tick and o_wrap one-cycle pulses aligned with o_digits.
module m_bcd_counter4
  import bcd_pkg::*;
#(
  parameter int CLK_HZ  = 50_000_000,
  parameter int TICK_HZ = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_en,
  input  logic        i_up,
  input  logic        i_clr,
  input  logic        i_load,
  input  logic [15:0] i_load_val,
  output logic [15:0] o_digits,
  output logic        o_tick,
  output logic        o_wrap
);

  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int PW  = (DIV > 2) ? $clog2(DIV) : 1;

  if (DIV < 2) begin : g_bad_div
    $error("m_bcd_counter4: CLK_HZ / TICK_HZ must be at least 2");
  end

  logic [PW-1:0] pcnt;
  logic          tick;
  logic          count_step;
  logic [3:0]    step;
  logic [3:0]    carry;
  logic [3:0]    borrow;
  logic [15:0]   digits;

  // Prescaler tick; only meaningful while running.
  assign tick = i_en && (pcnt == PW'(DIV - 1));

  // Clear and load both swallow a coincident tick.
  assign count_step = tick && !i_clr && !i_load;

  // Load leaves the prescaler running normally so the tick phase is kept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcnt <= '0;
    end else if (i_clr) begin
      pcnt <= '0;
    end else if (tick) begin
      pcnt <= '0;
    end else if (i_en) begin
      pcnt <= pcnt + PW'(1);
    end
  end

  // Each decade steps when the one below it carries or borrows.
  assign step[0]   = count_step;
  assign step[3:1] = carry[2:0] | borrow[2:0];

  for (genvar g = 0; g < 4; g++) begin : g_digit
    m_bcd_digit u_digit (
      .clk      (clk),
      .rst_n    (rst_n),
      .i_step   (step[g]),
      .i_up     (i_up),
      .i_clr    (i_clr),
      .i_load   (i_load),
      .i_val    (i_load_val[4*g +: 4]),
      .o_val    (digits[4*g +: 4]),
      .o_carry  (carry[g]),
      .o_borrow (borrow[g])
    );
  end

  // Pulses are registered on the same edge as the digits, so they line up
  // with the new value; a ripple out of the top decade is a wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_tick <= 1'b0;
      o_wrap <= 1'b0;
    end else begin
      o_tick <= count_step;
      o_wrap <= carry[3] | borrow[3];
    end
  end

  assign o_digits = digits;

endmodule

// File: doc/m_bcd_counter4.md
# m_bcd_counter4

Four-digit decimal (BCD) up/down counter with a built-in prescaler; it sits directly upstream of the per-digit seven-segment decoders. Each 4-bit digit output drives one decoder's digit input, so the display shows 0000–9999. The block provides a paced count tick, direction control, synchronous clear and parallel load, and flags wrap-around.

## Interface
- `CLK_HZ`, default 50_000_000: input clock frequency.
- `TICK_HZ`, default 10: count rate. `DIV = CLK_HZ / TICK_HZ`, with `DIV >= 2` required (elaboration error otherwise).
- `clk` input, 1 bit: system clock, rising edge.
- `rst_n` input, 1 bit: asynchronous, active-low reset.
- `i_en` input, 1 bit: run. 1 = prescaler advances and counts occur; 0 = counter and prescaler both hold.
- `i_up` input, 1 bit: direction. 1 = increment, 0 = decrement. Sampled on the tick cycle.
- `i_clr` input, 1 bit: synchronous clear of digits and prescaler.
- `i_load` input, 1 bit: synchronous parallel load of `i_load_val`.
- `i_load_val` input, 16 bits: four BCD digits, [15:12] most significant.
- `o_digits` output, 16 bits: registered BCD value, [3:0] least significant digit, each nibble 0–9.
- `o_tick` output, 1 bit: registered pulse, high for one cycle on each count step.
- `o_wrap` output, 1 bit: registered pulse, high for one cycle when the value wraps.

## Operation
- Prescaler `pcnt` counts 0..DIV-1.
  - Internal tick = `i_en && pcnt == DIV-1`.
  - On tick, `pcnt` returns to 0.
  - When `i_en = 0`, `pcnt` holds (pause keeps phase).
- Per-edge priority:
  - `i_clr`: digits become 0000, `pcnt` becomes 0, no tick or wrap pulse.
  - Otherwise `i_load`: digits take `i_load_val`, with any nibble >9 saturated to 9. `pcnt` is unaffected and a coincident tick is discarded.
  - Otherwise tick: count one step.
- Up-count: the least significant digit increments. A digit at 9 goes to 0 and carries into the next digit. At 9999 the value goes to 0000 and `o_wrap` pulses.
- Down-count: a digit at 0 goes to 9 and borrows from the next digit. At 0000 the value goes to 9999 and `o_wrap` pulses.
- Digits never hold values outside 0–9.
- Reset values: `o_digits` = 16'h0000, `o_tick` = 0, `o_wrap` = 0, `pcnt` = 0.
- Reset is honoured mid-count, mid-load or mid-pause, with no glitching of the registered outputs afterwards.

## Timing
- The first tick after reset with `i_en` held at 1 comes on edge DIV. Subsequent ticks come every DIV edges.
- `o_digits` changes on the same edge that the internal tick is sampled. `o_tick` and `o_wrap` go high in that same cycle, so they align with the new digit value, and drop on the next edge.
- `i_clr` and `i_load` take effect on the next edge, i.e. one-cycle latency to `o_digits`.
- Toggling `i_up` between ticks has no effect until the next tick.
- Deasserting `i_en` exactly on a would-be tick edge suppresses that tick.

## Structure
- Shared package `bcd_pkg`:
  - 4-bit BCD digit typedef.
  - Constants `BCD_MAX = 4'd9` and `BCD_MIN = 4'd0`.
  - Function `bcd_sat` (nibble >9 → 9).
- Sub-module `m_bcd_digit`: one decade.
  - Inputs: `clk`, `rst_n`, `i_step`, `i_up`, `i_clr`, `i_load`, `i_val`.
  - Outputs: `o_val`, plus combinational `o_carry` (= `i_step && i_up && val == 9`) and `o_borrow` (= `i_step && !i_up && val == 0`).
  - Instantiated four times, each stage's carry/borrow feeding the next stage's `i_step`.
- The top module holds the prescaler, priority logic and output pulse registers.

## Test plan
All scenarios use `CLK_HZ = 10`, `TICK_HZ = 1` (DIV = 10).
- Reset, then `i_en = 1`, `i_up = 1` for 25 clocks → `o_digits` = 0001 at edge 10 and 0002 at edge 20; `o_tick` high exactly on those two cycles.
- Load 16'h0998, count up 3 ticks → 0999, 1000, 1001; `o_wrap` stays 0.
- Load 16'h9999, up 1 tick → 0000 with `o_wrap` = 1 for one cycle. Then `i_up = 0`, 1 tick → 9999 with `o_wrap` = 1 again.
- Load 16'hAF3C → `o_digits` = 16'h9939. Assert `i_clr` and `i_load` together → 0000 (clear wins).
- Pause: `i_en = 0` at `pcnt = 5` for 20 clocks, then resume → next tick arrives 5 clocks after resume; value unchanged during the pause.
- Assert `rst_n = 0` asynchronously mid-prescale at value 0042 → outputs are 0 immediately. After release, the first tick comes on edge 10.
